// File: rtl/cpu_run_monitor_pkg.sv
// Shared types for the CPU run monitor: FSM state encoding, halt-cause codes
// and the helper that ranks simultaneous halt requests.
package cpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_BUDGET = 2'b01;
    localparam logic [1:0] ST_LOOP   = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

    // Abort outranks a loop hit, which outranks an exhausted budget.
    function automatic logic [1:0] halt_cause(input logic abort_req,
                                              input logic loop_req,
                                              input logic budget_req);
        logic [1:0] cause;
        cause = ST_NONE;
        if (abort_req) begin
            cause = ST_ABORT;
        end else if (loop_req) begin
            cause = ST_LOOP;
        end else if (budget_req) begin
            cause = ST_BUDGET;
        end
        return cause;
    endfunction

endpackage

// File: rtl/cpu_run_monitor_loop.sv
// Self-loop detector: counts consecutive retirements at the same PC and flags
// the retirement that reaches LOOP_LIMIT repeats.
module run_loop_detector #(
    parameter int LOOP_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        insn_vld,
    input  logic [31:0] pc,
    output logic        loop_hit
);

    localparam int CNT_W = $clog2(LOOP_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LOOP_LIMIT);

    logic [31:0]      last_pc;
    logic             last_vld;
    logic [CNT_W-1:0] loop_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             repeat_pc;

    // last_vld keeps the first retirement of a run from matching a stale PC.
    assign repeat_pc = en && insn_vld && last_vld && (pc == last_pc);
    assign cnt_next  = (loop_cnt == LIMIT) ? loop_cnt : loop_cnt + 1'b1;
    assign loop_hit  = repeat_pc && (cnt_next == LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            loop_cnt <= '0;
        end else if (clr) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            loop_cnt <= '0;
        end else if (en && insn_vld) begin
            last_pc  <= pc;
            last_vld <= 1'b1;
            loop_cnt <= repeat_pc ? cnt_next : '0;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller/observer for the single-cycle core: reset sequencing, cycle and
// retirement counters, halt on budget/loop/abort. Snapshot flops exist only when
// CPU_RUN_MONITOR_SNAPSHOT_EN is defined; otherwise o_snapshot is tied to zero.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 3,
    parameter int CYC_W      = 24,
    parameter int RST_CYCLES = 2,
    parameter int LOOP_LIMIT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [CYC_W-1:0]         i_budget,
    input  logic [31:0]              i_pc,
    input  logic                     i_insn_vld,
    input  logic [NUM_CH*DATA_W-1:0] i_watch,
    output logic                     o_cpu_rst,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [1:0]               o_status,
    output logic [CYC_W-1:0]         o_cycles,
    output logic [CYC_W-1:0]         o_retired,
    output logic [NUM_CH*DATA_W-1:0] o_snapshot
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    run_state_t       state;
    run_state_t       next_state;
    logic [RST_W-1:0] rst_cnt;
    logic             enter_reset;
    logic             halt;
    logic [1:0]       halt_status;
    logic             loop_hit;
    logic             budget_hit;
    logic [CYC_W-1:0] cycles_inc;
    logic [CYC_W-1:0] retired_inc;

    // Halts are judged on the post-increment counts so they land on the same edge.
    assign cycles_inc  = (o_cycles == '1) ? o_cycles : o_cycles + 1'b1;
    assign retired_inc = (!i_insn_vld || o_retired == '1) ? o_retired : o_retired + 1'b1;
    assign budget_hit  = (i_budget != '0) && (cycles_inc == i_budget);

    run_loop_detector #(
        .LOOP_LIMIT(LOOP_LIMIT)
    ) u_loop (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .clr      (enter_reset),
        .en       (state == RUN),
        .insn_vld (i_insn_vld),
        .pc       (i_pc),
        .loop_hit (loop_hit)
    );

    always_comb begin
        next_state  = state;
        enter_reset = 1'b0;
        halt        = 1'b0;
        halt_status = ST_NONE;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    next_state  = RESET;
                    enter_reset = 1'b1;
                end
            end
            RESET: begin
                if (rst_cnt == RST_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                halt        = i_abort || loop_hit || budget_hit;
                halt_status = halt_cause(i_abort, loop_hit, budget_hit);
                if (halt) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they switch with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            rst_cnt   <= '0;
            o_cpu_rst <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_status  <= ST_NONE;
            o_cycles  <= '0;
            o_retired <= '0;
        end else begin
            state     <= next_state;
            o_cpu_rst <= (next_state == IDLE) || (next_state == RESET);
            o_busy    <= (next_state == RESET) || (next_state == RUN);
            o_done    <= (next_state == DONE);
            if (enter_reset) begin
                rst_cnt   <= '0;
                o_status  <= ST_NONE;
                o_cycles  <= '0;
                o_retired <= '0;
            end else if (state == RESET) begin
                rst_cnt <= rst_cnt + 1'b1;
            end else if (state == RUN) begin
                o_cycles  <= cycles_inc;
                o_retired <= retired_inc;
                if (halt) begin
                    o_status <= halt_status;
                end
            end
        end
    end

`ifdef CPU_RUN_MONITOR_SNAPSHOT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_snapshot <= '0;
        end else if (enter_reset) begin
            o_snapshot <= '0;
        end else if (state == RUN && halt) begin
            o_snapshot <= i_watch;
        end
    end
`else
    logic unused_watch;
    assign unused_watch = ^i_watch;
    assign o_snapshot   = '0;
`endif

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and observer for the single-cycle RISC-V core. It holds the core in reset, releases it on command, and counts cycles and retired instructions. It stops the run on a cycle budget, a detected self-loop (e.g. the `jal x0,0` end-of-program idiom) or an external abort, then freezes a snapshot of N watched register channels. It replaces fixed-delay `$stop` benches and fixed `checkx*` probes with a parametrised, on-chip equivalent.

## Interface
Parameters:
- DATA_W, 32, width of one watch channel
- NUM_CH, 3, number of watch channels (≥1)
- CYC_W, 24, width of cycle and retired counters
- RST_CYCLES, 2, cycles the core is held in reset after start (≥1)
- LOOP_LIMIT, 4, consecutive repeated-PC retirements that count as a halt loop (≥1)

Ports:
- i_clk  in  1  clock; all logic on its rising edge
- i_rst_n  in  1  reset, asynchronous assert and active-low
- i_start  in  1  one-cycle start request
- i_abort  in  1  abort request; level, sampled every cycle
- i_budget  in  CYC_W  cycle limit for RUN; 0 means unlimited
- i_pc  in  32  core PC
- i_insn_vld  in  1  core retired an instruction this cycle
- i_watch  in  NUM_CH*DATA_W  watched values; channel k is bits [k*DATA_W +: DATA_W]
- o_cpu_rst  out  1  active-high reset to the core
- o_busy  out  1  state is RESET or RUN
- o_done  out  1  run finished; sticky until the next start
- o_status  out  2  halt cause: 00 none, 01 budget, 10 loop, 11 abort
- o_cycles  out  CYC_W  RUN cycles elapsed
- o_retired  out  CYC_W  instructions retired in RUN
- o_snapshot  out  NUM_CH*DATA_W  i_watch captured at halt

## Operation
- FSM has four states: IDLE, RESET, RUN, DONE.
- IDLE: o_cpu_rst=1. On i_start, go to RESET.
- RESET: o_cpu_rst=1 for exactly RST_CYCLES cycles, then go to RUN. Entry to RESET clears counters, status, o_done, snapshot and the loop tracker.
- RUN: o_cpu_rst=0.
  - o_cycles increments every cycle and saturates at all-ones.
  - o_retired increments when i_insn_vld=1 and also saturates.
- Loop tracker (active only in RUN):
  - On a valid instruction whose PC equals the last valid PC, loop_cnt increments. On a valid instruction with a different PC, loop_cnt clears. The last valid PC updates on every valid instruction.
  - The first valid instruction after entering RUN never counts as a repeat.
- Halt conditions, evaluated each RUN cycle, in priority order:
  - abort (i_abort=1)
  - loop (incremented loop_cnt == LOOP_LIMIT)
  - budget (i_budget≠0 and incremented o_cycles == i_budget)
- On halt: go to DONE, set o_status, capture o_snapshot from i_watch, freeze counters.
- DONE: o_done=1. o_cpu_rst=0, so the core keeps running and its state stays observable. i_start goes to RESET.
- i_start in RESET or RUN is ignored. i_abort outside RUN is ignored.
- Unlimited budget with saturated o_cycles: RUN continues until loop or abort.

## Timing
- Reset values: state IDLE, o_cpu_rst=1, o_busy=0, o_done=0, o_status=00, o_cycles=0, o_retired=0, o_snapshot=0, loop tracker cleared.
- Asserting i_rst_n low mid-run forces all of the above immediately, without waiting for a clock edge.
- All outputs are registered.
- i_start sampled at edge E:
  - o_busy=1 from E.
  - o_cpu_rst stays 1 through edge E+RST_CYCLES, falls at that edge.
  - First RUN cycle is the cycle after E+RST_CYCLES.
- Halt is detected and registered at the same edge as the terminating increment:
  - For a budget halt, o_cycles == i_budget exactly when o_done rises.
  - o_snapshot holds the i_watch value sampled at that edge.
- o_busy falls and o_done rises at the same edge.
- i_start while in DONE: o_done falls at the next edge.

## Configuration
- CPU_RUN_MONITOR_SNAPSHOT_EN defined: snapshot register present and behaves as above.
- Undefined: no snapshot flops; o_snapshot is constant 0; all other behaviour unchanged.

## Structure
- Package cpu_run_monitor_pkg holds the state enum (IDLE/RESET/RUN/DONE) and the status constants (ST_NONE, ST_BUDGET, ST_LOOP, ST_ABORT).
- Sub-module run_loop_detector contains the last-PC register, valid flag and loop_cnt. It outputs a one-cycle loop_hit. It is cleared by a synchronous clr input from the FSM.

## Test plan
- Reset, then i_start with RST_CYCLES=2 -> o_cpu_rst high for 2 cycles after start; o_busy=1; o_cycles=0 on the first RUN edge.
- i_budget=100, PC advancing by 4 with i_insn_vld=1 every cycle -> o_done at the 100th RUN edge; o_status=01; o_cycles=100; o_retired=100.
- PC advancing, then stuck at 0x40 with i_insn_vld=1 -> DONE after 4 repeats (LOOP_LIMIT=4), status 10; o_snapshot channel 1 equals the driven x1 value.
- i_abort and loop hit in the same cycle -> o_status=11.
- i_rst_n pulsed low mid-RUN -> all outputs at reset values immediately; a later i_start restarts cleanly with counters at 0.
- i_budget=0, CYC_W=4, PC advancing -> o_cycles saturates at 15; RUN continues until abort; then i_start in DONE -> o_done clears and counters reset.
